// File: rtl/scanline_pingpong_buffer_pkg.sv
// Shared types and default sizing for the scanline ping-pong buffer.
// Lock-state encoding plus the default line geometry.
package scanline_pingpong_buffer_pkg;

    localparam int LINE_PIX_DEF = 160;
    localparam int PIX_W_DEF    = 7;
    localparam int SCALE_DEF    = 4;
    localparam int XPOS_W_DEF   = 8;
    localparam int HPOS_W_DEF   = 10;

    typedef enum logic [1:0] {
        WAIT_SRC = 2'd0,
        WAIT_DST = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

endpackage

// File: rtl/scanline_pingpong_buffer_if.sv
// Signal bundle between the video source/sink side and the buffer.
// master drives writes and timing, slave returns pixels and status.
interface scanline_pingpong_buffer_if
    import scanline_pingpong_buffer_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int XPOS_W = XPOS_W_DEF,
    parameter int HPOS_W = HPOS_W_DEF
);
    logic              wr_en;
    logic [XPOS_W-1:0] wr_xpos;
    logic [PIX_W-1:0]  wr_data;
    logic              src_line_done;
    logic              src_vsync;
    logic              dst_line_start;
    logic              dst_vsync;
    logic              rd_active;
    logic [HPOS_W-1:0] rd_hpos;
    logic              resync;
    logic [PIX_W-1:0]  pix_out;
    logic              pix_valid;
    logic              locked;
    logic [7:0]        stale_cnt;

    modport master (
        output wr_en, wr_xpos, wr_data, src_line_done, src_vsync,
        output dst_line_start, dst_vsync, rd_active, rd_hpos, resync,
        input  pix_out, pix_valid, locked, stale_cnt
    );

    modport slave (
        input  wr_en, wr_xpos, wr_data, src_line_done, src_vsync,
        input  dst_line_start, dst_vsync, rd_active, rd_hpos, resync,
        output pix_out, pix_valid, locked, stale_cnt
    );
endinterface

// File: rtl/scanline_pingpong_buffer_line_bank_ram.sv
// One scanline bank: single write port, registered read port.
// Contents are not reset; reads return pre-write data on collision.
module line_bank_ram #(
    parameter int DEPTH = 160,
    parameter int W     = 7,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/scanline_pingpong_buffer.sv
// Two-bank line buffer bridging a source line rate to an upscaled
// output raster, with a vsync-based frame lock and stale-line counter.
module scanline_pingpong_buffer
    import scanline_pingpong_buffer_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int LINE_PIX = LINE_PIX_DEF,
    parameter int SCALE    = SCALE_DEF,
    parameter int XPOS_W   = XPOS_W_DEF,
    parameter int HPOS_W   = HPOS_W_DEF
) (
    input  logic clk,
    input  logic reset,
    scanline_pingpong_buffer_if.slave bus
);
    localparam int AW = $clog2(LINE_PIX);
    localparam int SH = $clog2(SCALE);
    localparam logic [HPOS_W-1:0] LP_H = HPOS_W'(LINE_PIX);
    localparam logic [XPOS_W-1:0] LP_X = XPOS_W'(LINE_PIX);

    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    logic        ready_q, ready_d;
    logic [7:0]  stale_q, stale_d;
    logic        src_vs_q, dst_vs_q;
    logic        sel_q, in_range_q, valid_q;
    lock_state_t state_q, state_d;
    logic        locked;

    logic [HPOS_W-1:0] rd_idx;
    logic              in_range;
    logic [AW-1:0]     rd_addr;
    logic              wr_ok;
    logic [PIX_W-1:0]  rd_data0, rd_data1;
    logic              src_fall, dst_rise;

    assign rd_idx   = bus.rd_hpos >> SH;
    assign in_range = bus.rd_active && (rd_idx < LP_H);
    assign rd_addr  = in_range ? rd_idx[AW-1:0] : '0;
    assign wr_ok    = bus.wr_en && (bus.wr_xpos < LP_X);

    line_bank_ram #(.DEPTH(LINE_PIX), .W(PIX_W), .AW(AW)) u_bank0 (
        .clk       (clk),
        .we_i      (wr_ok && !wr_bank_q),
        .wr_addr_i (bus.wr_xpos[AW-1:0]),
        .wr_data_i (bus.wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data0)
    );

    line_bank_ram #(.DEPTH(LINE_PIX), .W(PIX_W), .AW(AW)) u_bank1 (
        .clk       (clk),
        .we_i      (wr_ok && wr_bank_q),
        .wr_addr_i (bus.wr_xpos[AW-1:0]),
        .wr_data_i (bus.wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data1)
    );

    // A same-cycle handoff goes straight to the reader, never marked unshown.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        ready_d   = ready_q;
        stale_d   = stale_q;
        if (bus.src_line_done) begin
            wr_bank_d = ~wr_bank_q;
            ready_d   = 1'b1;
        end
        if (bus.dst_line_start) begin
            if (bus.src_line_done) begin
                rd_bank_d = wr_bank_q;
                ready_d   = 1'b0;
            end else if (ready_q) begin
                rd_bank_d = ~wr_bank_q;
                ready_d   = 1'b0;
            end else if (stale_q != 8'hFF) begin
                stale_d = stale_q + 8'd1;
            end
        end
    end

    assign src_fall = src_vs_q && !bus.src_vsync;
    assign dst_rise = !dst_vs_q && bus.dst_vsync;

    always_comb begin
        state_d = state_q;
        if (bus.resync) begin
            state_d = WAIT_SRC;
        end else begin
            unique case (state_q)
                WAIT_SRC: if (src_fall) state_d = WAIT_DST;
                WAIT_DST: if (dst_rise) state_d = LOCKED;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        locked = 1'b0;
        unique case (state_q)
            LOCKED:  locked = 1'b1;
            default: locked = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b1;
            ready_q    <= 1'b0;
            stale_q    <= 8'd0;
            src_vs_q   <= 1'b0;
            dst_vs_q   <= 1'b0;
            state_q    <= WAIT_SRC;
            sel_q      <= 1'b1;
            in_range_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            ready_q    <= ready_d;
            stale_q    <= stale_d;
            src_vs_q   <= bus.src_vsync;
            dst_vs_q   <= bus.dst_vsync;
            state_q    <= state_d;
            sel_q      <= rd_bank_q;
            in_range_q <= in_range;
            valid_q    <= in_range && locked;
        end
    end

    assign bus.pix_out   = in_range_q ? (sel_q ? rd_data1 : rd_data0) : '0;
    assign bus.pix_valid = valid_q;
    assign bus.locked    = locked;
    assign bus.stale_cnt = stale_q;
endmodule

// File: tb/tb_scanline_pingpong_buffer.sv
// Directed plus randomized bench for the scanline ping-pong buffer,
// checked against a line-level reference model.
module tb_scanline_pingpong_buffer;
    import scanline_pingpong_buffer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scanline_pingpong_buffer_if #(.PIX_W(7), .XPOS_W(8), .HPOS_W(10)) bus ();

    scanline_pingpong_buffer #(
        .PIX_W(7), .LINE_PIX(160), .SCALE(4), .XPOS_W(8), .HPOS_W(10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // reference model: line memories, bank bookkeeping, lock progress
    logic [6:0] mmem  [2][160];
    bit         known [2][160];
    bit         m_wr, m_rd, m_done, m_ready;
    int         m_stale;
    int         m_phase;
    bit         m_svs, m_dvs;
    logic [6:0] e_pix;
    bit         e_valid, pix_known;

    int errs   = 0;
    int checks = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 1; m_done = 0; m_ready = 0;
        m_stale = 0; m_phase = 0; m_svs = 0; m_dvs = 0;
        e_pix = '0; e_valid = 0;
    endtask

    task automatic tick();
        int idx;
        bit inr;
        idx = int'(bus.rd_hpos) / 4;
        inr = bus.rd_active && (idx < 160);
        @(posedge clk);
        e_valid   = inr && (m_phase == 2);
        pix_known = !inr || known[m_rd][idx];
        e_pix     = inr ? mmem[m_rd][idx] : 7'd0;
        if (bus.wr_en && bus.wr_xpos < 8'd160) begin
            mmem[m_wr][bus.wr_xpos]  = bus.wr_data;
            known[m_wr][bus.wr_xpos] = 1;
        end
        if (bus.src_line_done) begin
            m_done = m_wr; m_wr = !m_wr; m_ready = 1;
        end
        if (bus.dst_line_start) begin
            if (m_ready) begin
                m_rd = m_done; m_ready = 0;
            end else if (m_stale < 255) begin
                m_stale++;
            end
        end
        if (bus.resync) m_phase = 0;
        else if (m_phase == 0 && m_svs && !bus.src_vsync) m_phase = 1;
        else if (m_phase == 1 && !m_dvs && bus.dst_vsync) m_phase = 2;
        m_svs = bus.src_vsync;
        m_dvs = bus.dst_vsync;
        #1;
        if (pix_known) chk("pix_out", bus.pix_out, e_pix);
        chk("pix_valid", bus.pix_valid, e_valid);
        chk("locked", bus.locked, m_phase == 2);
        chk("stale_cnt", bus.stale_cnt, m_stale);
        bus.wr_en = 0; bus.src_line_done = 0;
        bus.dst_line_start = 0; bus.resync = 0;
    endtask

    task automatic write_line(input int base);
        for (int x = 0; x < 160; x++) begin
            bus.wr_en = 1; bus.wr_xpos = 8'(x); bus.wr_data = 7'(base + x);
            tick();
        end
        bus.src_line_done = 1;
        tick();
    endtask

    task automatic read_at(input int h);
        bus.rd_active = 1; bus.rd_hpos = 10'(h);
        tick();
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_xpos = '0; bus.wr_data = '0;
        bus.src_line_done = 0; bus.src_vsync = 0;
        bus.dst_line_start = 0; bus.dst_vsync = 0;
        bus.rd_active = 0; bus.rd_hpos = '0; bus.resync = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pix", bus.pix_out, 0);
        chk("rst_valid", bus.pix_valid, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_stale", bus.stale_cnt, 0);
        reset = 0;
        model_reset();

        bus.dst_vsync = 1; tick();
        bus.dst_vsync = 0; tick();
        chk("no_lock_dst_only", bus.locked, 0);
        bus.src_vsync = 1; tick();
        bus.src_vsync = 0; tick();
        bus.dst_vsync = 1; tick();
        chk("lock_after_rise", bus.locked, 1);

        write_line(7'h10);
        bus.dst_line_start = 1; tick();
        write_line(7'h40);

        bus.wr_en = 1; bus.wr_xpos = 8'd5; bus.wr_data = 7'h2A; tick();
        bus.src_line_done = 1; tick();
        bus.dst_line_start = 1; tick();
        read_at(20);
        chk("px5_data", bus.pix_out, 7'h2A);
        chk("px5_valid", bus.pix_valid, 1);

        bus.wr_en = 1; bus.wr_xpos = 8'd160; bus.wr_data = 7'h7F; tick();
        read_at(636);
        chk("idx159_data", bus.pix_out, 7'h2F);
        read_at(640);
        chk("oob_data", bus.pix_out, 0);
        chk("oob_valid", bus.pix_valid, 0);

        bus.src_line_done = 1; tick();
        repeat (3) begin bus.dst_line_start = 1; tick(); end
        chk("stale_two", bus.stale_cnt, 2);
        read_at(20);
        chk("stale_bank_kept", bus.pix_out, 7'h45);

        bus.wr_en = 1; bus.wr_xpos = 8'd5; bus.wr_data = 7'h33; tick();
        bus.src_line_done = 1; bus.dst_line_start = 1; tick();
        chk("simul_stale", bus.stale_cnt, 2);
        read_at(21);
        chk("simul_bank", bus.pix_out, 7'h33);
        bus.dst_line_start = 1; tick();
        chk("simul_ready_clr", bus.stale_cnt, 3);
        repeat (300) begin bus.dst_line_start = 1; tick(); end
        chk("stale_sat", bus.stale_cnt, 255);

        bus.resync = 1; tick();
        chk("resync_unlock", bus.locked, 0);
        bus.dst_vsync = 0; tick();
        bus.dst_vsync = 1; tick();
        chk("resync_dst_only", bus.locked, 0);
        bus.src_vsync = 1; tick();
        bus.src_vsync = 0; tick();
        bus.dst_vsync = 0; tick();
        bus.dst_vsync = 1; tick();
        chk("relock", bus.locked, 1);

        bus.wr_en = 1; bus.wr_xpos = 8'd9; bus.wr_data = 7'h55; tick();
        read_at(20);
        #2 reset = 1;
        #1;
        chk("arst_pix", bus.pix_out, 0);
        chk("arst_valid", bus.pix_valid, 0);
        chk("arst_locked", bus.locked, 0);
        chk("arst_stale", bus.stale_cnt, 0);
        bus.rd_active = 0;
        @(posedge clk);
        #1 reset = 0;
        model_reset();

        for (int i = 0; i < 3000; i++) begin
            bus.wr_en = 1'($urandom);
            bus.wr_xpos = 8'($urandom_range(0, 170));
            bus.wr_data = 7'($urandom);
            bus.src_line_done = ($urandom % 40) == 0;
            bus.dst_line_start = ($urandom % 40) == 0;
            bus.rd_active = ($urandom % 4) != 0;
            bus.rd_hpos = 10'($urandom_range(0, 700));
            if ($urandom % 60 == 0) bus.src_vsync = !bus.src_vsync;
            if ($urandom % 60 == 0) bus.dst_vsync = !bus.dst_vsync;
            bus.resync = ($urandom % 700) == 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/scanline_pingpong_buffer.md
SCANLINE_PINGPONG_BUFFER -- requirements
Module: scanline_pingpong_buffer

Interface
REQ-001 Parameters (name, default, meaning): PIX_W, 7, hue/luma bits per pixel; LINE_PIX, 160, source pixels per line; SCALE, 4, output pixels per source pixel (power of two); XPOS_W, 8, source x width; HPOS_W, 10, output x width.
REQ-002 clk  in  1  single clock for both write and read sides.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 wr_en  in  1  write strobe for the source pixel.
REQ-005 wr_xpos  in  XPOS_W  source pixel index.
REQ-006 wr_data  in  PIX_W  source pixel colour.
REQ-007 src_line_done  in  1  one-cycle pulse at the end of a source line.
REQ-008 src_vsync  in  1  source vertical sync level.
REQ-009 dst_line_start  in  1  one-cycle pulse at the start of an output line.
REQ-010 dst_vsync  in  1  output vertical sync level.
REQ-011 rd_active  in  1  output display-on.
REQ-012 rd_hpos  in  HPOS_W  output x position.
REQ-013 resync  in  1  one-cycle pulse that forces reacquisition of frame lock.
REQ-014 pix_out  out  PIX_W  registered pixel.
REQ-015 pix_valid  out  1  pix_out is displayable.
REQ-016 locked  out  1  frame lock FSM is in LOCKED.
REQ-017 stale_cnt  out  8  saturating count of output lines that reused an already-shown bank.

Function
REQ-018 Storage: two banks of LINE_PIX x PIX_W; wr_bank selects the bank being written, rd_bank selects the bank being read.
REQ-019 Write: when wr_en=1 and wr_xpos<LINE_PIX, write wr_data to bank wr_bank at wr_xpos; when wr_xpos>=LINE_PIX, drop the write.
REQ-020 On src_line_done: toggle wr_bank and set ready=1; ready marks the just-completed bank (~new wr_bank) as unshown.
REQ-021 On dst_line_start: if ready=1, load rd_bank from the completed bank and clear ready; otherwise keep rd_bank and increment stale_cnt, saturating at 255.
REQ-022 Simultaneous src_line_done and dst_line_start: the reader latches the bank completed in that same cycle, and ready ends at 0.
REQ-023 Read index: rd_hpos/SCALE, computed by shift with no divider; the index is in range when it is <LINE_PIX and rd_active=1.
REQ-024 Latency: pix_out and pix_valid update exactly one cycle after rd_hpos/rd_active.
REQ-025 pix_out: the bank rd_bank entry when in range, otherwise 0.
REQ-026 pix_valid = in range AND locked, registered.
REQ-027 A read and a write to the same bank and address in the same cycle return the old contents (read-before-write).
REQ-028 Lock FSM states: WAIT_SRC, WAIT_DST, LOCKED.
REQ-029 WAIT_SRC -> WAIT_DST on a src_vsync falling edge (prev=1, now=0).
REQ-030 WAIT_DST -> LOCKED on a dst_vsync rising edge.
REQ-031 Any state -> WAIT_SRC on resync; resync has priority over every other transition.
REQ-032 Edge detectors use one registered copy of each vsync; after reset an edge requires an observed transition.

Reset
REQ-033 Reset asynchronously clears: wr_bank=0, rd_bank=1, ready=0, stale_cnt=0, FSM=WAIT_SRC, vsync history=0, pix_out=0, pix_valid=0, locked=0.
REQ-034 Buffer memory is not reset; it is unreadable as valid until lock is reached.
REQ-035 Reset asserted mid-line discards the partial line and clears ready.

Structure
REQ-036 A shared package holds the lock-state enum and the default parameter constants (LINE_PIX, PIX_W, SCALE).
REQ-037 One sub-module, line_bank_ram (single write port, single registered read port, depth LINE_PIX), is instantiated twice; the top-level multiplexes between the two instances by bank.
REQ-038 Target size: 120-400 RTL lines; no multipliers or dividers.

Verification
REQ-039 Write pixel 5 = 0x2A, pulse src_line_done, pulse dst_line_start, drive rd_hpos=20 with rd_active=1 and the FSM locked -> the next cycle gives pix_out=0x2A and pix_valid=1.
REQ-040 wr_xpos=160 with wr_data=0x7F -> no memory changes; rd_hpos=636 gives the entry at index 159 unchanged; rd_hpos=640 gives pix_out=0 and pix_valid=0.
REQ-041 Three dst_line_start pulses after one src_line_done -> stale_cnt=2 and rd_bank unchanged; 300 stale lines -> stale_cnt=255.
REQ-042 src_line_done and dst_line_start in the same cycle -> rd_bank equals the just-completed bank, ready=0, stale_cnt unchanged.
REQ-043 Sequence src_vsync 1->0, then dst_vsync 0->1 -> locked=1 the cycle after the rising edge; a resync pulse -> locked=0 the next cycle and the FSM in WAIT_SRC; dst_vsync rising alone in WAIT_SRC -> no lock.
REQ-044 Reset asserted mid-frame while locked -> all outputs 0 asynchronously, before the next clk edge.
